// File: rtl/decode_uop_queue_pkg.sv
// Shared decode/rename types, queue sizing constants and the lane popcount helper.
// Imported by the decode uop queue, its lane compactor and its port interface.
package decode_uop_queue_pkg;

    localparam int unsigned DEC_WIDTH = 4;
    localparam int unsigned DUQ_DEPTH = 16;
    localparam int unsigned LANE_CNT_W = $clog2(DEC_WIDTH + 1);

    typedef logic [LANE_CNT_W-1:0] lane_cnt_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] imm;
        logic [5:0]  opcode;
        logic [4:0]  rd;
    } D_UOp;

    typedef struct packed {
        logic        taken;
        logic [31:0] dstPC;
    } BranchProv;

    // Number of valid lanes in one decode group.
    function automatic lane_cnt_t popcount_lanes(input logic [DEC_WIDTH-1:0] v);
        lane_cnt_t n;
        n = '0;
        for (int unsigned i = 0; i < DEC_WIDTH; i++) begin
            n = n + lane_cnt_t'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/decode_uop_queue_if.sv
// Decoder-side and rename-side signals of the decode uop queue.
// The queue takes the slave modport; the driving pipeline takes master.
interface decode_uop_queue_if
    import decode_uop_queue_pkg::*;
#(
    parameter int unsigned DEPTH     = DUQ_DEPTH,
    parameter int unsigned WIDTH_IN  = DEC_WIDTH,
    parameter int unsigned WIDTH_OUT = DEC_WIDTH
) ();

    D_UOp      [WIDTH_IN-1:0]  IN_uop;
    logic                      OUT_full;
    logic                      IN_rnStall;
    BranchProv                 IN_branch;
    logic                      IN_mispredFlush;
    D_UOp      [WIDTH_OUT-1:0] OUT_uop;
    logic [$clog2(DEPTH):0]    OUT_count;

    modport master (
        output IN_uop, IN_rnStall, IN_branch, IN_mispredFlush,
        input  OUT_full, OUT_uop, OUT_count
    );

    modport slave (
        input  IN_uop, IN_rnStall, IN_branch, IN_mispredFlush,
        output OUT_full, OUT_uop, OUT_count
    );

endinterface

// File: rtl/decode_uop_queue_compact.sv
// Combinational lane compactor: prefix sum over valid bits gives each lane
// its slot offset from the write pointer, plus the total number of valid lanes.
module duq_compact
    import decode_uop_queue_pkg::*;
#(
    parameter  int unsigned WIDTH_IN = DEC_WIDTH,
    localparam int unsigned CW       = $clog2(WIDTH_IN + 1)
) (
    input  logic [WIDTH_IN-1:0]         valid_i,
    output logic [WIDTH_IN-1:0][CW-1:0] offset_o,
    output logic [CW-1:0]               count_o
);

    logic [CW-1:0] acc;

    always_comb begin
        acc      = '0;
        offset_o = '0;
        for (int unsigned i = 0; i < WIDTH_IN; i++) begin
            offset_o[i] = acc;
            acc         = acc + CW'(valid_i[i]);
        end
        count_o = acc;
    end

endmodule

// File: rtl/decode_uop_queue.sv
// Elastic circular uop buffer between decode and rename: compacts sparse decode
// lanes in program order, presents the oldest uops, flushes on a taken branch.
module decode_uop_queue
    import decode_uop_queue_pkg::*;
#(
    parameter int unsigned DEPTH     = DUQ_DEPTH,
    parameter int unsigned WIDTH_IN  = DEC_WIDTH,
    parameter int unsigned WIDTH_OUT = DEC_WIDTH
) (
    input logic               clk,
    input logic               rst,
    decode_uop_queue_if.slave bus
);

    localparam int unsigned PW   = $clog2(DEPTH);
    localparam int unsigned CNTW = PW + 1;
    localparam int unsigned CW   = $clog2(WIDTH_IN + 1);

    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNTW-1:0] count_q,  count_d;
    D_UOp            entries_q [DEPTH];

    logic [WIDTH_IN-1:0]         in_valid;
    logic [WIDTH_IN-1:0][CW-1:0] lane_off;
    logic [CW-1:0]               push_lanes;
    logic [CNTW-1:0]             n_push, n_pop, free_slots;
    logic                        full, flush, push_en, pop_en;

    always_comb begin
        in_valid = '0;
        for (int unsigned i = 0; i < WIDTH_IN; i++) begin
            in_valid[i] = bus.IN_uop[i].valid;
        end
    end

    duq_compact #(.WIDTH_IN(WIDTH_IN)) u_compact (
        .valid_i (in_valid),
        .offset_o(lane_off),
        .count_o (push_lanes)
    );

    // Full looks at the current occupancy only; a same-cycle pop does not free it.
    assign free_slots = CNTW'(DEPTH) - count_q;
    assign full       = free_slots < CNTW'(WIDTH_IN);
    assign flush      = bus.IN_branch.taken;
    assign push_en    = !full && !flush;
    assign pop_en     = !bus.IN_rnStall && !bus.IN_mispredFlush && !flush;

    always_comb begin
        n_push = push_en ? CNTW'(push_lanes) : '0;
        n_pop  = '0;
        if (pop_en) begin
            n_pop = (count_q < CNTW'(WIDTH_OUT)) ? count_q : CNTW'(WIDTH_OUT);
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q + PW'(n_pop);
        wr_ptr_d = wr_ptr_q + PW'(n_push);
        count_d  = count_q + n_push - n_pop;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage is deliberately unreset; occupancy gates every read.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < WIDTH_IN; i++) begin
            if (push_en && in_valid[i]) begin
                entries_q[wr_ptr_q + PW'(lane_off[i])] <= bus.IN_uop[i];
            end
        end
    end

    always_comb begin
        bus.OUT_uop = '0;
        for (int unsigned k = 0; k < WIDTH_OUT; k++) begin
            bus.OUT_uop[k]       = entries_q[rd_ptr_q + PW'(k)];
            bus.OUT_uop[k].valid = entries_q[rd_ptr_q + PW'(k)].valid
                                   && (count_q > CNTW'(k))
                                   && !bus.IN_mispredFlush;
        end
    end

    assign bus.OUT_full  = full;
    assign bus.OUT_count = count_q;

endmodule

// File: tb/tb_decode_uop_queue.sv
// Directed bench for decode_uop_queue: vector table plus hand-written sequences
// for async reset, fill/back-pressure, wrap streaming, branch flush and mispredict mask.
module tb_decode_uop_queue;
    import decode_uop_queue_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned WI    = 4;
    localparam int unsigned WO    = 4;

    logic        clk = 1'b0;
    logic        rst;
    int unsigned checks = 0;
    int unsigned errors = 0;

    decode_uop_queue_if #(.DEPTH(DEPTH), .WIDTH_IN(WI), .WIDTH_OUT(WO)) bus ();

    decode_uop_queue #(.DEPTH(DEPTH), .WIDTH_IN(WI), .WIDTH_OUT(WO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  vmask;
        logic [31:0] imm0;
        logic        stall;
        logic        taken;
        logic        mispred;
        logic [4:0]  e_count;
        logic        e_full;
        logic [3:0]  e_valid;
        logic [31:0] e_imm0;
        logic [31:0] e_imm1;
    } vec_t;

    vec_t        vecs [10];
    int unsigned model [$];
    int unsigned tag, n, npop;
    logic [3:0]  ev;
    logic        full_m;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic set_lane(input int unsigned i, input logic v, input logic [31:0] imm);
        D_UOp u;
        u.valid  = v;
        u.imm    = imm;
        u.opcode = 6'(i + 1);
        u.rd     = 5'(i + 2);
        bus.IN_uop[i] = u;
    endtask

    task automatic push_vec(input logic [3:0] vmask, input logic [31:0] imm0);
        for (int unsigned i = 0; i < WI; i++) set_lane(i, vmask[i], imm0 + i);
    endtask

    task automatic set_ctl(input logic stall, input logic taken, input logic mispred);
        BranchProv b;
        b.taken             = taken;
        b.dstPC             = 32'h0000_1000;
        bus.IN_branch       = b;
        bus.IN_rnStall      = stall;
        bus.IN_mispredFlush = mispred;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [3:0] out_valid();
        logic [3:0] r;
        for (int k = 0; k < 4; k++) r[k] = bus.OUT_uop[k].valid;
        return r;
    endfunction

    task automatic do_reset();
        push_vec(4'b0000, 32'h0);
        set_ctl(1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Structural invariants, sampled just before each rising edge.
    always begin
        @(negedge clk);
        #4;
        if (rst === 1'b1) begin
            checks++;
            if (dut.count_q > 5'(DEPTH)
                || 4'(dut.wr_ptr_q - dut.rd_ptr_q) != dut.count_q[3:0]
                || (bus.OUT_full && dut.push_en)) begin
                errors++;
                $display("FAIL invariant: count=%0d wr=%0d rd=%0d full=%0b push_en=%0b",
                         dut.count_q, dut.wr_ptr_q, dut.rd_ptr_q, bus.OUT_full, dut.push_en);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{4'b1010, 32'h10, 1'b1, 1'b0, 1'b0, 5'd2, 1'b0, 4'b0011, 32'h11, 32'h13};
        vecs[1] = '{4'b1111, 32'h20, 1'b1, 1'b0, 1'b0, 5'd6, 1'b0, 4'b1111, 32'h11, 32'h13};
        vecs[2] = '{4'b0000, 32'h00, 1'b0, 1'b0, 1'b0, 5'd2, 1'b0, 4'b0011, 32'h22, 32'h23};
        vecs[3] = '{4'b0101, 32'h30, 1'b0, 1'b0, 1'b0, 5'd2, 1'b0, 4'b0011, 32'h30, 32'h32};
        vecs[4] = '{4'b1000, 32'h40, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0, 4'b0000, 32'h30, 32'h32};
        vecs[5] = '{4'b0000, 32'h00, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 4'b0000, 32'h30, 32'h32};
        vecs[6] = '{4'b0000, 32'h00, 1'b1, 1'b0, 1'b0, 5'd3, 1'b0, 4'b0111, 32'h30, 32'h32};
        vecs[7] = '{4'b1111, 32'h50, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 4'b0000, 32'h0,  32'h0};
        vecs[8] = '{4'b0001, 32'h60, 1'b1, 1'b0, 1'b0, 5'd1, 1'b0, 4'b0001, 32'h60, 32'h0};
        vecs[9] = '{4'b0000, 32'h00, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 4'b0000, 32'h0,  32'h0};

        rst = 1'b0;
        push_vec(4'b0000, 32'h0);
        set_ctl(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("reset_count", 32'(bus.OUT_count), 32'd0);
        chk("reset_full",  32'(bus.OUT_full),  32'd0);
        chk("reset_valid", 32'(out_valid()),   32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            push_vec(vecs[i].vmask, vecs[i].imm0);
            set_ctl(vecs[i].stall, vecs[i].taken, vecs[i].mispred);
            tick();
            chk($sformatf("vec%0d_count", i), 32'(bus.OUT_count), 32'(vecs[i].e_count));
            chk($sformatf("vec%0d_full", i),  32'(bus.OUT_full),  32'(vecs[i].e_full));
            chk($sformatf("vec%0d_valid", i), 32'(out_valid()),   32'(vecs[i].e_valid));
            if (vecs[i].e_valid[0]) chk($sformatf("vec%0d_imm0", i), bus.OUT_uop[0].imm, vecs[i].e_imm0);
            if (vecs[i].e_valid[1]) chk($sformatf("vec%0d_imm1", i), bus.OUT_uop[1].imm, vecs[i].e_imm1);
        end

        // Asynchronous reset with 9 entries queued.
        push_vec(4'b1111, 32'h80); set_ctl(1'b1, 1'b0, 1'b0); tick();
        push_vec(4'b1111, 32'h84); tick();
        push_vec(4'b0001, 32'h88); tick();
        chk("pre_reset_count", 32'(bus.OUT_count), 32'd9);
        push_vec(4'b0000, 32'h0);
        #2 rst = 1'b0;
        #1;
        chk("async_reset_count", 32'(bus.OUT_count), 32'd0);
        chk("async_reset_valid", 32'(out_valid()),   32'd0);
        chk("async_reset_full",  32'(bus.OUT_full),  32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("post_reset_count", 32'(bus.OUT_count), 32'd0);

        // Sparse lanes {1,3} compact into slots 0,1.
        do_reset();
        set_lane(0, 1'b0, 32'h0); set_lane(1, 1'b1, 32'hA);
        set_lane(2, 1'b0, 32'h0); set_lane(3, 1'b1, 32'hB);
        set_ctl(1'b1, 1'b0, 1'b0);
        tick();
        chk("sparse_imm0",  bus.OUT_uop[0].imm,    32'hA);
        chk("sparse_imm1",  bus.OUT_uop[1].imm,    32'hB);
        chk("sparse_valid", 32'(out_valid()),      32'b0011);
        chk("sparse_count", 32'(bus.OUT_count),    32'd2);

        // Fill to DEPTH under stall, then release.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            push_vec(4'b1111, 32'(4 * c));
            set_ctl(1'b1, 1'b0, 1'b0);
            tick();
            if (c == 2) begin
                chk("fill12_count", 32'(bus.OUT_count), 32'd12);
                chk("fill12_full",  32'(bus.OUT_full),  32'd0);
            end
        end
        chk("fill16_count", 32'(bus.OUT_count), 32'd16);
        chk("fill16_full",  32'(bus.OUT_full),  32'd1);
        push_vec(4'b1111, 32'h99); tick();
        chk("full_ignore_count", 32'(bus.OUT_count), 32'd16);
        chk("full_ignore_imm0",  bus.OUT_uop[0].imm, 32'd0);
        set_ctl(1'b0, 1'b0, 1'b0); tick();
        chk("release_count", 32'(bus.OUT_count), 32'd12);
        chk("release_full",  32'(bus.OUT_full),  32'd0);
        chk("release_imm0",  bus.OUT_uop[0].imm, 32'd4);
        push_vec(4'b0001, 32'h50); set_ctl(1'b1, 1'b0, 1'b0); tick();
        chk("fill13_count", 32'(bus.OUT_count), 32'd13);
        chk("fill13_full",  32'(bus.OUT_full),  32'd1);
        push_vec(4'b1111, 32'h60); tick();
        chk("full13_ignore_count", 32'(bus.OUT_count), 32'd13);
        push_vec(4'b0000, 32'h0); set_ctl(1'b0, 1'b0, 1'b0);
        tick();
        chk("drain1_imm0", bus.OUT_uop[0].imm, 32'd8);
        tick();
        chk("drain2_imm0", bus.OUT_uop[0].imm, 32'd12);
        tick();
        chk("drain3_count", 32'(bus.OUT_count), 32'd1);
        chk("drain3_imm0",  bus.OUT_uop[0].imm, 32'h50);

        // Position rdPtr at 14 with six tagged entries, then stream across the wrap.
        do_reset();
        for (int c = 0; c < 3; c++) begin
            push_vec(4'b1111, 32'h100); set_ctl(1'b1, 1'b0, 1'b0); tick();
        end
        push_vec(4'b0000, 32'h0); set_ctl(1'b0, 1'b0, 1'b0);
        tick(); tick(); tick();
        push_vec(4'b0011, 32'h100); set_ctl(1'b1, 1'b0, 1'b0); tick();
        push_vec(4'b0000, 32'h0); set_ctl(1'b0, 1'b0, 1'b0); tick();
        push_vec(4'b1111, 32'd0); set_ctl(1'b1, 1'b0, 1'b0); tick();
        push_vec(4'b0011, 32'd4); tick();
        chk("wrap_setup_rdptr", 32'(dut.rd_ptr_q),  32'd14);
        model.delete();
        for (int unsigned t = 0; t < 6; t++) model.push_back(t);
        tag = 6;
        for (int c = 0; c < 100; c++) begin
            n  = model.size();
            ev = '0;
            for (int k = 0; k < 4; k++) ev[k] = (k < int'(n));
            chk("stream_count", 32'(bus.OUT_count), n);
            chk("stream_valid", 32'(out_valid()), 32'(ev));
            for (int k = 0; k < 4; k++) begin
                if (k < int'(n)) chk("stream_imm", bus.OUT_uop[k].imm, model[k]);
            end
            push_vec(4'b0111, tag);
            set_ctl(1'b0, 1'b0, 1'b0);
            full_m = (DEPTH - n) < WI;
            tick();
            npop = (n < WO) ? n : WO;
            repeat (npop) void'(model.pop_front());
            if (!full_m) begin
                for (int unsigned j = 0; j < 3; j++) model.push_back(tag + j);
                tag = tag + 3;
            end
        end
        chk("stream_final_count", 32'(bus.OUT_count), model.size());

        // Taken branch alongside a 4-lane push with 7 queued.
        do_reset();
        push_vec(4'b1111, 32'h200); set_ctl(1'b1, 1'b0, 1'b0); tick();
        push_vec(4'b0111, 32'h204); tick();
        chk("pre_flush_count", 32'(bus.OUT_count), 32'd7);
        push_vec(4'b1111, 32'h300); set_ctl(1'b1, 1'b1, 1'b0); tick();
        chk("flush_count", 32'(bus.OUT_count), 32'd0);
        chk("flush_valid", 32'(out_valid()),   32'd0);
        push_vec(4'b0000, 32'h0); set_ctl(1'b1, 1'b0, 1'b0); tick();
        chk("flush_idle_count", 32'(bus.OUT_count), 32'd0);
        push_vec(4'b0001, 32'h77); tick();
        chk("post_flush_count", 32'(bus.OUT_count), 32'd1);
        chk("post_flush_valid", 32'(out_valid()),   32'b0001);
        chk("post_flush_imm0",  bus.OUT_uop[0].imm, 32'h77);

        // Mispredict flush masks output for three cycles without popping.
        do_reset();
        push_vec(4'b1111, 32'h400); set_ctl(1'b1, 1'b0, 1'b0); tick();
        push_vec(4'b0001, 32'h404); tick();
        push_vec(4'b0000, 32'h0);
        for (int c = 0; c < 3; c++) begin
            set_ctl(1'b0, 1'b0, 1'b1);
            #1;
            chk("mispred_valid", 32'(out_valid()),   32'd0);
            chk("mispred_count", 32'(bus.OUT_count), 32'd5);
            tick();
        end
        chk("mispred_end_count", 32'(bus.OUT_count), 32'd5);
        set_ctl(1'b1, 1'b0, 1'b0);
        #1;
        chk("mispred_release_valid", 32'(out_valid()), 32'b1111);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("mispred_release_imm%0d", k), bus.OUT_uop[k].imm, 32'h400 + 32'(k));
        end
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
